// File: rtl/sd_rrmux_pkg.sv
// Shared types and round-robin helper for the quota-limited requester mux.
package sd_rrmux_pkg;

  localparam int unsigned RR_INPUTS = 4;
  localparam int unsigned RR_DEPTH  = 16;
  localparam int unsigned RR_MAX    = 32;
  localparam int unsigned TAG_W     = $clog2(RR_INPUTS);
  localparam int unsigned CNT_W     = $clog2(RR_DEPTH + 1);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // One-hot grant for the first requester after ptr, wrapping n-1 -> 0.
  function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                input int unsigned        ptr,
                                                input int unsigned        n);
    logic [RR_MAX-1:0] g;
    logic              found;
    logic [4:0]        idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = 5'((ptr + k) % n);
      if (k <= n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sd_rr_arb.sv
// Combinational round-robin arbiter: request vector and pointer to one-hot grant and index.
module sd_rr_arb
  import sd_rrmux_pkg::*;
#(
  parameter int unsigned n  = 4,
  parameter int unsigned tw = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [tw-1:0] ptr,
  output logic [n-1:0]  grant_c,
  output logic [tw-1:0] idx_c
);

  always_comb begin
    grant_c = n'(rr_next(RR_MAX'(req), 32'(ptr), n));
    idx_c   = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (grant_c[i]) idx_c = tw'(i);
    end
  end

endmodule

// File: rtl/sd_quota_rrmux.sv
// Round-robin mux into a shared buffer with per-requester occupancy quotas.
// Optional packet hold (grant sticks until c_eop) under SD_RRMUX_PKT_HOLD_EN.
module sd_quota_rrmux
  import sd_rrmux_pkg::*;
#(
  parameter  int unsigned inputs = 4,
  parameter  int unsigned width  = 8,
  parameter  int unsigned depth  = 16,
  parameter  int unsigned quota  = 8,
  localparam int unsigned tsz    = $clog2(inputs),
  localparam int unsigned usz    = $clog2(depth + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [inputs-1:0]                c_srdy,
  output logic [inputs-1:0]                c_drdy,
  input  logic [inputs-1:0][width-1:0]     c_data,
`ifdef SD_RRMUX_PKT_HOLD_EN
  input  logic [inputs-1:0]                c_eop,
`endif
  output logic                             p_srdy,
  input  logic                             p_drdy,
  output logic [width-1:0]                 p_data,
  output logic [tsz-1:0]                   p_tag,
  input  logic                             rel_vld,
  input  logic [tsz-1:0]                   rel_tag,
  output logic [inputs-1:0][usz-1:0]       usage,
  output logic [usz-1:0]                   total
);

  localparam logic [usz-1:0] QUOTA_C = usz'(quota);
  localparam logic [usz-1:0] DEPTH_C = usz'(depth);

  logic [tsz-1:0]              ptr;
  logic [inputs-1:0]           elig;
  logic [inputs-1:0]           arb_grant;
  logic [inputs-1:0]           grant;
  logic [tsz-1:0]              arb_idx;
  logic [tsz-1:0]              gidx;
  logic                        load_ok;
  logic                        acc;
  logic                        rel_ok;
  logic [inputs-1:0][usz-1:0]  usage_d;
  logic [usz-1:0]              total_d;

  // Eligibility counts the beat sitting in the output register against total.
  always_comb begin
    for (int unsigned i = 0; i < inputs; i++) begin
      elig[i] = c_srdy[i] && (usage[i] < QUOTA_C) && (total < DEPTH_C);
    end
  end

  sd_rr_arb #(.n(inputs), .tw(tsz)) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .grant_c (arb_grant),
    .idx_c   (arb_idx)
  );

`ifdef SD_RRMUX_PKT_HOLD_EN
  logic           hold;
  logic [tsz-1:0] holder;

  // A held requester keeps the grant even if it is currently ineligible (stall).
  always_comb begin
    gidx  = hold ? holder : arb_idx;
    grant = hold ? (elig & (inputs'(1) << holder)) : arb_grant;
  end
`else
  always_comb begin
    gidx  = arb_idx;
    grant = arb_grant;
  end
`endif

  assign load_ok = !p_srdy || p_drdy;
  assign c_drdy  = (!reset && load_ok) ? grant : '0;
  assign acc     = |c_drdy;
  assign rel_ok  = rel_vld && (32'(rel_tag) < inputs) && (usage[rel_tag] != '0);

  // Occupancy update; a release on an empty owner is dropped.
  always_comb begin
    total_d = total;
    if (acc && !rel_ok)      total_d = total + usz'(1);
    else if (!acc && rel_ok) total_d = total - usz'(1);
    for (int unsigned i = 0; i < inputs; i++) begin
      usage_d[i] = usage[i];
      if (c_drdy[i] && !(rel_ok && rel_tag == tsz'(i)))      usage_d[i] = usage[i] + usz'(1);
      else if (!c_drdy[i] && rel_ok && rel_tag == tsz'(i))   usage_d[i] = usage[i] - usz'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy <= 1'b0;
      p_data <= '0;
      p_tag  <= '0;
      usage  <= '0;
      total  <= '0;
      ptr    <= tsz'(inputs - 1);
`ifdef SD_RRMUX_PKT_HOLD_EN
      hold   <= 1'b0;
      holder <= '0;
`endif
    end else begin
      usage <= usage_d;
      total <= total_d;
      if (acc) begin
        p_srdy <= 1'b1;
        p_data <= c_data[gidx];
        p_tag  <= gidx;
`ifdef SD_RRMUX_PKT_HOLD_EN
        if (c_eop[gidx]) begin
          hold <= 1'b0;
          ptr  <= gidx;
        end else begin
          hold   <= 1'b1;
          holder <= gidx;
        end
`else
        ptr <= gidx;
`endif
      end else if (p_drdy) begin
        p_srdy <= 1'b0;
      end
    end
  end

`ifdef SD_INLINE_ASSERTION_ON
  logic [31:0] usage_sum;

  always_comb begin
    usage_sum = '0;
    for (int unsigned i = 0; i < inputs; i++) usage_sum = usage_sum + 32'(usage[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (total <= DEPTH_C) else $error("total exceeds depth");
      for (int unsigned i = 0; i < inputs; i++) begin
        assert (usage[i] <= QUOTA_C) else $error("usage exceeds quota");
      end
      assert ($onehot0(c_drdy)) else $error("c_drdy not onehot0");
      assert (32'(total) == usage_sum) else $error("total differs from usage sum");
      if (rel_vld) begin
        assert (usage[rel_tag] != '0) else $error("release on owner with zero usage");
      end
    end
  end
`endif

endmodule

// File: tb/tb_sd_quota_rrmux.sv
// Scoreboard bench for sd_quota_rrmux: directed stimulus pushes expected beats, a monitor pops them.
module tb_sd_quota_rrmux;
  import sd_rrmux_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned TW = 2;
  localparam int unsigned UW = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          c_srdy;
  logic [N-1:0]          c_drdy;
  logic [N-1:0][W-1:0]   c_data;
`ifdef SD_RRMUX_PKT_HOLD_EN
  logic [N-1:0]          c_eop;
`endif
  logic                  p_srdy;
  logic                  p_drdy;
  logic [W-1:0]          p_data;
  logic [TW-1:0]         p_tag;
  logic                  rel_vld;
  logic [TW-1:0]         rel_tag;
  logic [N-1:0][UW-1:0]  usage;
  logic [UW-1:0]         total;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
  } beat_t;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fails = 0;

  always #5 clk = ~clk;

  sd_quota_rrmux #(.inputs(N), .width(W), .depth(16), .quota(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_data  (c_data),
`ifdef SD_RRMUX_PKT_HOLD_EN
    .c_eop   (c_eop),
`endif
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data),
    .p_tag   (p_tag),
    .rel_vld (rel_vld),
    .rel_tag (rel_tag),
    .usage   (usage),
    .total   (total)
  );

  function automatic logic [W-1:0] dval(input int i);
    return W'(32'hA0 + i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int tag);
    sb.push_back(beat_t'{tag: TW'(tag), data: dval(tag)});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    c_srdy  = '0;
    rel_vld = 1'b0;
    rel_tag = '0;
    p_drdy  = 1'b1;
`ifdef SD_RRMUX_PKT_HOLD_EN
    c_eop   = '1;
`endif
    tick(2);
    reset = 1'b0;
  endtask

  // Monitor: every beat transferred downstream must match the head of the scoreboard.
  initial begin
    beat_t exp;
    forever begin
      @(negedge clk);
      if (!reset && p_srdy && p_drdy) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL unexpected_beat: got tag %0d data %0h, expected no beat", p_tag, p_data);
        end else begin
          exp = sb.pop_front();
          check("beat_tag", 32'(p_tag), 32'(exp.tag));
          check("beat_data", 32'(p_data), 32'(exp.data));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(N); i++) c_data[i] = dval(i);
    c_srdy  = '1;
    p_drdy  = 1'b1;
    rel_vld = 1'b0;
    rel_tag = '0;
`ifdef SD_RRMUX_PKT_HOLD_EN
    c_eop   = '1;
`endif
    tick(2);
    #1;
    check("reset_p_srdy", 32'(p_srdy), 32'd0);
    check("reset_p_data", 32'(p_data), 32'd0);
    check("reset_p_tag", 32'(p_tag), 32'd0);
    check("reset_total", 32'(total), 32'd0);
    check("reset_usage", 32'(usage), 32'd0);
    check("reset_c_drdy", 32'(c_drdy), 32'd0);

    // All requesters, no release: 0,1,2,3 repeating until the buffer is full.
    reset = 1'b0;
    for (int k = 0; k < 16; k++) expect_beat(k % 4);
    #1;
    check("t1_first_grant", 32'(c_drdy), 32'h1);
    tick(20);
    check("t1_total_full", 32'(total), 32'd16);
    for (int i = 0; i < int'(N); i++) check($sformatf("t1_usage%0d", i), 32'(usage[i]), 32'd4);
    check("t1_c_drdy_full", 32'(c_drdy), 32'd0);
    check("t1_p_srdy_idle", 32'(p_srdy), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Single requester limited by quota; one release frees exactly one more beat.
    do_reset();
    c_srdy = 4'b0100;
    repeat (8) expect_beat(2);
    tick(10);
    check("t2_usage_quota", 32'(usage[2]), 32'd8);
    check("t2_total", 32'(total), 32'd8);
    check("t2_c_drdy_blocked", 32'(c_drdy), 32'd0);
    rel_vld = 1'b1;
    rel_tag = 2'd2;
    tick();
    rel_vld = 1'b0;
    #1;
    check("t2_usage_released", 32'(usage[2]), 32'd7);
    check("t2_c_drdy_reopen", 32'(c_drdy), 32'h4);
    expect_beat(2);
    tick();
    check("t2_c_drdy_reblocked", 32'(c_drdy), 32'd0);
    check("t2_usage_refill", 32'(usage[2]), 32'd8);
    tick(2);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Downstream stall holds the output; release of stall grants the next requester at once.
    do_reset();
    p_drdy = 1'b0;
    c_srdy = 4'b0011;
    expect_beat(0);
    expect_beat(1);
    tick();
    check("t3_p_srdy", 32'(p_srdy), 32'd1);
    check("t3_c_drdy_stall", 32'(c_drdy), 32'd0);
    tick(2);
    check("t3_p_tag_hold", 32'(p_tag), 32'd0);
    check("t3_p_data_hold", 32'(p_data), 32'(dval(0)));
    check("t3_c_drdy_stall2", 32'(c_drdy), 32'd0);
    p_drdy = 1'b1;
    #1;
    check("t3_c_drdy_resume", 32'(c_drdy), 32'h2);
    tick();
    c_srdy = '0;
    #1;
    check("t3_p_tag_next", 32'(p_tag), 32'd1);
    check("t3_p_data_next", 32'(p_data), 32'(dval(1)));
    tick(2);
    check("t3_p_srdy_idle", 32'(p_srdy), 32'd0);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Accept and release on the same requester in one cycle leave counts unchanged.
    do_reset();
    c_srdy = 4'b0010;
    repeat (4) expect_beat(1);
    tick(3);
    c_srdy = '0;
    #1;
    check("t4_usage_pre", 32'(usage[1]), 32'd3);
    check("t4_total_pre", 32'(total), 32'd3);
    c_srdy  = 4'b0010;
    rel_vld = 1'b1;
    rel_tag = 2'd1;
    #1;
    check("t4_c_drdy", 32'(c_drdy), 32'h2);
    tick();
    c_srdy  = '0;
    rel_vld = 1'b0;
    #1;
    check("t4_usage_same", 32'(usage[1]), 32'd3);
    check("t4_total_same", 32'(total), 32'd3);
    tick(2);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Release on an empty owner is ignored; reset during a full stall clears everything.
    do_reset();
    rel_vld = 1'b1;
    rel_tag = 2'd0;
    tick();
    rel_vld = 1'b0;
    #1;
    check("t5_usage0_sat", 32'(usage[0]), 32'd0);
    check("t5_total_sat", 32'(total), 32'd0);
    c_srdy = '1;
    for (int k = 0; k < 15; k++) expect_beat(k % 4);
    tick(15);
    p_drdy = 1'b0;
    #1;
    check("t5_total_stall", 32'(total), 32'd15);
    check("t5_p_srdy_stall", 32'(p_srdy), 32'd1);
    check("t5_p_tag_stall", 32'(p_tag), 32'd2);
    check("t5_c_drdy_stall", 32'(c_drdy), 32'd0);
    tick(2);
    check("t5_sb_held", 32'(sb.size()), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_p_srdy", 32'(p_srdy), 32'd0);
    check("t5_rst_total", 32'(total), 32'd0);
    check("t5_rst_usage", 32'(usage), 32'd0);
    check("t5_rst_c_drdy", 32'(c_drdy), 32'd0);
    sb.delete();
    c_srdy = '0;
    p_drdy = 1'b1;
    reset  = 1'b0;
    tick(2);
    check("t5_post_p_srdy", 32'(p_srdy), 32'd0);

`ifdef SD_RRMUX_PKT_HOLD_EN
    // Requester 0 keeps the grant through its 3-beat packet while requester 1 waits.
    do_reset();
    c_eop  = 4'b1110;
    c_srdy = 4'b0011;
    expect_beat(0);
    expect_beat(0);
    expect_beat(0);
    expect_beat(1);
    tick(2);
    c_eop[0] = 1'b1;
    tick();
    c_srdy = 4'b0010;
    tick();
    c_srdy = '0;
    tick(3);
    check("t6_usage0", 32'(usage[0]), 32'd3);
    check("t6_usage1", 32'(usage[1]), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
